thermo_shift_out: RTL
=====================

# thermo_shift_out

Output stage behind the thermometer-code generator. Takes the 15-bit thermometer count, checks it for bubbles (non-contiguous ones), corrects it, and converts it to binary. Whenever the corrected value changes, it serialises one 16-bit frame to an external 74HC595-style LED bar shift register using a serial clock, data and latch strobe. The frame is the error flag followed by the corrected code.

## Interface
Parameters:
- SCLK_DIV, 4, number of clk cycles in each sclk phase (high, low) and in the latch pulse. Legal range is 1..255.

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-low reset
- thermo_in  input  15  thermometer code; bit i set means level > i
- sclk  output  1  serial clock to the shift register; data sampled on its rising edge
- sdata  output  1  serial data, MSB first
- latch  output  1  storage-register strobe; high for SCLK_DIV cycles after the 16th bit
- busy  output  1  high while a frame is in progress
- level  output  4  binary popcount of the registered input (0..15)
- bubble_err  output  1  high when the registered input is not a valid thermometer code

## Operation
- Stage 1: thermo_in is registered into code_q every cycle.
- Stage 2, registered from code_q:
  - level = popcount(code_q).
  - corr = thermometer(level), i.e. the low `level` bits set.
  - bubble_err = (code_q != corr).
- Frame word = {bubble_err, corr[14:0]}, snapshot when the frame starts. Bit 15 is sent first.
- Registers: sent holds the corr value of the last frame; force is a flag set by reset.
- FSM states are IDLE, SHIFT_LO, SHIFT_HI, LATCH.
  - IDLE: sclk=0, latch=0, busy=0. If force=1 or corr != sent:
    - load the shift register;
    - sent <= corr; force <= 0;
    - bit_cnt <= 15; div_cnt <= 0;
    - sdata <= bubble_err;
    - go to SHIFT_LO.
  - SHIFT_LO: sclk=0, busy=1, for SCLK_DIV cycles, then go to SHIFT_HI.
  - SHIFT_HI: sclk=1 for SCLK_DIV cycles. At the end:
    - if bit_cnt == 0, go to LATCH with sdata <= 0;
    - otherwise shift left, bit_cnt--, sdata <= next bit, and go to SHIFT_LO.
  - LATCH: latch=1, sclk=0, for SCLK_DIV cycles, then go to IDLE.
- sdata changes only on the SHIFT_HI→SHIFT_LO or IDLE→SHIFT_LO transitions, so it is stable for the whole sclk-high phase.
- An input change during a frame does not disturb the frame. After the frame returns to IDLE, the newest corr is compared against sent. Intermediate values may be skipped.
- A corrected value equal to sent produces no frame, even if bubble_err changed.
- Reset: all outputs 0, FSM to IDLE, code_q=0, sent=0, force=1.
  - The first frame after reset sends 16'h0000.
  - Reset in the middle of a frame aborts it. No latch pulse is issued for the partial frame.

## Timing
- level and bubble_err are valid 2 cycles after thermo_in is sampled.
- From a thermo_in change (sampled at edge N), busy=1 and the first sdata appear at edge N+3.
- Frame duration with busy=1 is 33*SCLK_DIV cycles: 16 bits × 2 phases, plus the latch.
- There is at least 1 IDLE cycle (busy=0) between consecutive frames.
- There are exactly 16 sclk rising edges and 1 latch pulse per frame. sclk and latch are never high together.
- div_cnt counts 0..SCLK_DIV-1. bit_cnt is 4 bits and counts 15..0. No wrap-around occurs inside a frame.
- When SCLK_DIV=1, sclk toggles every cycle and latch is a 1-cycle pulse.

## Test plan
- Release reset with thermo_in=0 and SCLK_DIV=2. Required response:
  - one forced frame of 16'h0000;
  - busy is high for 66 cycles;
  - 16 sclk rises, then latch high for 2 cycles;
  - no further frames while the input stays constant.
- Drive thermo_in=15'h007F (level 7). Required response:
  - level=7 and bubble_err=0 after 2 cycles;
  - the frame shifted MSB first is 16'h007F.
- Drive thermo_in=15'h000B (a bubble). Required response:
  - level=3 and bubble_err=1;
  - frame = 16'h8007.
- Step thermo_in 15'h0001→15'h0003→15'h0007 while busy. Required response:
  - the current frame completes unchanged;
  - exactly one following frame, carrying 16'h0007;
  - 15'h0003 is never sent.
- Assert reset mid-frame, at bit 8. Required response:
  - sclk, sdata, latch and busy are 0 on the next edge;
  - no latch pulse for the partial frame;
  - after release, a forced 16'h0000 frame is sent.
- Drive thermo_in=15'h7FFF with SCLK_DIV=1. Required response:
  - frame = 16'h7FFF;
  - busy is high for 33 cycles;
  - sdata is stable at every sclk rising edge.

Source files
------------

// File: rtl/thermo_shift_out.sv
// Bubble-corrects a 15-bit thermometer code, reports its binary level, and shifts
// {bubble_err, corrected code} MSB first to a 74HC595-style LED bar on each change.
module thermo_shift_out #(
    parameter int SCLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] thermo_in,
    output logic        sclk,
    output logic        sdata,
    output logic        latch,
    output logic        busy,
    output logic [3:0]  level,
    output logic        bubble_err
);
    localparam logic [7:0] DIV_LAST = 8'(SCLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

    logic [14:0] code_reg;
    logic [14:0] corr_reg;
    logic [14:0] sent_reg;
    logic [14:0] corr_next;
    logic [3:0]  level_next;
    logic [15:0] frame_reg;
    logic [3:0]  bit_cnt_reg;
    logic [7:0]  div_cnt_reg;
    logic        force_reg;
    logic        phase_done;
    state_t      state_reg;

    always_comb begin
        level_next = '0;
        for (int i = 0; i < 15; i++) begin
            level_next = level_next + {3'b000, code_reg[i]};
        end
    end

    // Corrected code keeps exactly the low `level` bits set.
    generate
        for (genvar gi = 0; gi < 15; gi++) begin : g_corr
            assign corr_next[gi] = (level_next > 4'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            code_reg   <= '0;
            level      <= '0;
            corr_reg   <= '0;
            bubble_err <= 1'b0;
        end else begin
            code_reg   <= thermo_in;
            level      <= level_next;
            corr_reg   <= corr_next;
            bubble_err <= (code_reg != corr_next);
        end
    end

    assign phase_done = (div_cnt_reg == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= IDLE;
            sclk        <= 1'b0;
            sdata       <= 1'b0;
            latch       <= 1'b0;
            busy        <= 1'b0;
            frame_reg   <= '0;
            sent_reg    <= '0;
            force_reg   <= 1'b1;
            bit_cnt_reg <= '0;
            div_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (force_reg || (corr_reg != sent_reg)) begin
                        frame_reg   <= {bubble_err, corr_reg};
                        sent_reg    <= corr_reg;
                        force_reg   <= 1'b0;
                        bit_cnt_reg <= 4'd15;
                        div_cnt_reg <= '0;
                        sdata       <= bubble_err;
                        busy        <= 1'b1;
                        state_reg   <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (phase_done) begin
                        div_cnt_reg <= '0;
                        sclk        <= 1'b1;
                        state_reg   <= SHIFT_HI;
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 8'd1;
                    end
                end
                SHIFT_HI: begin
                    if (phase_done) begin
                        div_cnt_reg <= '0;
                        sclk        <= 1'b0;
                        if (bit_cnt_reg == 4'd0) begin
                            sdata     <= 1'b0;
                            latch     <= 1'b1;
                            state_reg <= LATCH;
                        end else begin
                            // Data moves only as sclk falls, so it is stable across the high phase.
                            frame_reg   <= {frame_reg[14:0], 1'b0};
                            sdata       <= frame_reg[14];
                            bit_cnt_reg <= bit_cnt_reg - 4'd1;
                            state_reg   <= SHIFT_LO;
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 8'd1;
                    end
                end
                LATCH: begin
                    if (phase_done) begin
                        div_cnt_reg <= '0;
                        latch       <= 1'b0;
                        busy        <= 1'b0;
                        state_reg   <= IDLE;
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 8'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
